// File: rtl/sdrc_arb_pkg.sv
// Shared definitions for the SDRAM request arbiter: FSM state encoding,
// arbitration mode encoding and a reference round-robin pick function.
package sdrc_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic ARB_MODE_RR  = 1'b0;
    localparam logic ARB_MODE_FIX = 1'b1;

    // Round-robin pick over up to 8 ports: first requester found when
    // searching last_gnt+1 .. last_gnt+num_ports (mod num_ports).
    // Returns last_gnt when nothing is requesting.
    function automatic logic [2:0] rr_pick(input logic [7:0] req_vec,
                                           input logic [2:0] last_gnt,
                                           input int         num_ports);
        logic [2:0] w;
        int         idx;
        w = last_gnt;
        // Walk from the farthest candidate back to the nearest so the
        // nearest asserted port is the one left in w.
        for (int i = num_ports; i >= 1; i--) begin
            idx = (int'(last_gnt) + i) % num_ports;
            if (req_vec[idx[2:0]]) w = idx[2:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the port
// after last_gnt sits at bit 0, priority-encode, then rotate the index back.
module sdrc_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PW        = 2
) (
    input  logic [NUM_PORTS-1:0] req_vec,
    input  logic [PW-1:0]        last_gnt,
    output logic [PW-1:0]        pick,
    output logic                 any
);

    logic [NUM_PORTS-1:0] rot;
    logic [PW-1:0]        off;
    logic [PW-1:0]        idx;
    int                   t;

    // Rotate, find the lowest set offset, and map it back to a port index.
    always_comb begin
        rot  = '0;
        off  = '0;
        idx  = '0;
        t    = 0;
        pick = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            t      = (int'(last_gnt) + 1 + i) % NUM_PORTS;
            idx    = t[PW-1:0];
            rot[i] = req_vec[idx];
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) off = PW'(i);
        end
        t    = (int'(last_gnt) + 1 + int'(off)) % NUM_PORTS;
        pick = t[PW-1:0];
        any  = |req_vec;
    end

endmodule

// File: rtl/sdrc_req_arb.sv
// N-port request arbiter in front of the SDRAM request generator. Grants one
// requester at a time, captures its request fields, holds them on the single
// downstream port until req_ack, then pulses that port's port_ack.
`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif

module sdrc_req_arb
    import sdrc_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PW        = 2,
    parameter int APP_AW    = 30,
    parameter int APP_RW    = 9,
    parameter int ID_W      = `SDR_REQ_ID_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_arb_mode,
    input  logic [NUM_PORTS-1:0]        port_req,
    input  logic [NUM_PORTS*ID_W-1:0]   port_id,
    input  logic [NUM_PORTS*APP_AW-1:0] port_addr,
    input  logic [NUM_PORTS*APP_RW-1:0] port_len,
    input  logic [NUM_PORTS-1:0]        port_wr_n,
    input  logic [NUM_PORTS-1:0]        port_wrap,
    output logic [NUM_PORTS-1:0]        port_ack,
    output logic                        req,
    output logic [ID_W-1:0]             req_id,
    output logic [APP_AW-1:0]           req_addr,
    output logic [APP_RW-1:0]           req_len,
    output logic                        req_wr_n,
    output logic                        req_wrap,
    input  logic                        req_ack,
    output logic [PW-1:0]               arb_gnt,
    output logic                        arb_busy
);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     last_gnt_q, last_gnt_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [ID_W-1:0]   req_id_q, req_id_d;
    logic [APP_AW-1:0] req_addr_q, req_addr_d;
    logic [APP_RW-1:0] req_len_q, req_len_d;
    logic              req_wr_n_q, req_wr_n_d;
    logic              req_wrap_q, req_wrap_d;

    logic [PW-1:0]     rr_last;
    logic [PW-1:0]     win;
    logic              win_vld;
    logic [ID_W-1:0]   sel_id;
    logic [APP_AW-1:0] sel_addr;
    logic [APP_RW-1:0] sel_len;
    logic              sel_wr_n;
    logic              sel_wrap;

    // Fixed priority is a round-robin search that always starts after the
    // top port, so port 0 is checked first.
    assign rr_last = (cfg_arb_mode == ARB_MODE_FIX) ? PW'(NUM_PORTS - 1) : last_gnt_q;

    sdrc_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_pick (
        .req_vec  (port_req),
        .last_gnt (rr_last),
        .pick     (win),
        .any      (win_vld)
    );

    // Select the winning port's request fields.
    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_len  = '0;
        sel_wr_n = 1'b0;
        sel_wrap = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (win == PW'(k)) begin
                sel_id   = port_id[k*ID_W +: ID_W];
                sel_addr = port_addr[k*APP_AW +: APP_AW];
                sel_len  = port_len[k*APP_RW +: APP_RW];
                sel_wr_n = port_wr_n[k];
                sel_wrap = port_wrap[k];
            end
        end
    end

    // Next state: capture a winner in IDLE, release on req_ack in BUSY.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        req_id_d   = req_id_q;
        req_addr_d = req_addr_q;
        req_len_d  = req_len_q;
        req_wr_n_d = req_wr_n_q;
        req_wrap_d = req_wrap_q;
        case (state_q)
            ARB_IDLE: begin
                if (win_vld) begin
                    gnt_d      = win;
                    req_id_d   = sel_id;
                    req_addr_d = sel_addr;
                    req_len_d  = sel_len;
                    req_wr_n_d = sel_wr_n;
                    req_wrap_d = sel_wrap;
                    state_d    = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (req_ack) begin
                    last_gnt_d = gnt_q;
                    state_d    = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Accept pulse goes only to the granted port, in the req_ack cycle.
    always_comb begin
        port_ack = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            port_ack[k] = (state_q == ARB_BUSY) && req_ack && (gnt_q == PW'(k));
        end
    end

    // State and capture registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= PW'(NUM_PORTS - 1);
            gnt_q      <= '0;
            req_id_q   <= '0;
            req_addr_q <= '0;
            req_len_q  <= '0;
            req_wr_n_q <= 1'b0;
            req_wrap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            req_id_q   <= req_id_d;
            req_addr_q <= req_addr_d;
            req_len_q  <= req_len_d;
            req_wr_n_q <= req_wr_n_d;
            req_wrap_q <= req_wrap_d;
        end
    end

    assign req      = (state_q == ARB_BUSY);
    assign arb_busy = (state_q == ARB_BUSY);
    assign arb_gnt  = gnt_q;
    assign req_id   = req_id_q;
    assign req_addr = req_addr_q;
    assign req_len  = req_len_q;
    assign req_wr_n = req_wr_n_q;
    assign req_wrap = req_wrap_q;

endmodule

// File: tb/tb_sdrc_req_arb.sv
// Bench for sdrc_req_arb: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sdrc_req_arb;

    localparam int NP  = 4;
    localparam int PW  = 2;
    localparam int AW  = 30;
    localparam int RW  = 9;
    localparam int IDW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_arb_mode = 1'b0;
    logic              req_ack = 1'b0;
    logic [NP-1:0]     port_req = '0;
    logic [NP*IDW-1:0] port_id;
    logic [NP*AW-1:0]  port_addr;
    logic [NP*RW-1:0]  port_len;
    logic [NP-1:0]     port_wr_n;
    logic [NP-1:0]     port_wrap;
    logic [NP-1:0]     port_ack;
    logic              req;
    logic [IDW-1:0]    req_id;
    logic [AW-1:0]     req_addr;
    logic [RW-1:0]     req_len;
    logic              req_wr_n;
    logic              req_wrap;
    logic [PW-1:0]     arb_gnt;
    logic              arb_busy;

    sdrc_req_arb #(
        .NUM_PORTS (NP),
        .PW        (PW),
        .APP_AW    (AW),
        .APP_RW    (RW),
        .ID_W      (IDW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_arb_mode (cfg_arb_mode),
        .port_req     (port_req),
        .port_id      (port_id),
        .port_addr    (port_addr),
        .port_len     (port_len),
        .port_wr_n    (port_wr_n),
        .port_wrap    (port_wrap),
        .port_ack     (port_ack),
        .req          (req),
        .req_id       (req_id),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_wr_n     (req_wr_n),
        .req_wrap     (req_wrap),
        .req_ack      (req_ack),
        .arb_gnt      (arb_gnt),
        .arb_busy     (arb_busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Winner by the arbitration rule: fixed mode takes the lowest asserted
    // port; round robin takes the first asserted port after the last grant.
    function automatic int winner(input logic [NP-1:0] r, input logic mode, input int last);
        for (int s = 1; s <= NP; s++) begin
            int c;
            c = mode ? (s - 1) : ((last + s) % NP);
            if (r[c]) return c;
        end
        return -1;
    endfunction

    logic           m_valid = 1'b0;
    logic           m_busy;
    int             m_gnt;
    int             m_last;
    logic [IDW-1:0] m_id;
    logic [AW-1:0]  m_addr;
    logic [RW-1:0]  m_len;
    logic           m_wr_n;
    logic           m_wrap;
    int             m_w;

    assign m_w = winner(port_req, cfg_arb_mode, m_last);

    // Model advances one transaction step per clock.
    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_gnt   <= 0;
            m_last  <= NP - 1;
            m_id    <= '0;
            m_addr  <= '0;
            m_len   <= '0;
            m_wr_n  <= 1'b0;
            m_wrap  <= 1'b0;
        end else if (!m_busy) begin
            if (port_req != '0) begin
                m_busy <= 1'b1;
                m_gnt  <= m_w;
                m_id   <= port_id[m_w*IDW +: IDW];
                m_addr <= port_addr[m_w*AW +: AW];
                m_len  <= port_len[m_w*RW +: RW];
                m_wr_n <= port_wr_n[m_w];
                m_wrap <= port_wrap[m_w];
            end
        end else if (req_ack) begin
            m_busy <= 1'b0;
            m_last <= m_gnt;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("req",      {63'd0, req},      {63'd0, m_busy});
            check("arb_busy", {63'd0, arb_busy}, {63'd0, m_busy});
            check("arb_gnt",  64'(arb_gnt),      64'(m_gnt));
            check("req_id",   64'(req_id),       64'(m_id));
            check("req_addr", 64'(req_addr),     64'(m_addr));
            check("req_len",  64'(req_len),      64'(m_len));
            check("req_wr_n", {63'd0, req_wr_n}, {63'd0, m_wr_n});
            check("req_wrap", {63'd0, req_wrap}, {63'd0, m_wrap});
            check("port_ack", 64'(port_ack),     (m_busy && req_ack) ? (64'd1 << m_gnt) : 64'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    int glog[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req_ack      = 1'b0;
        port_req     = '0;
        cfg_arb_mode = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Downstream acks whenever req is up; logs the acked port index.
    task automatic auto_step();
        tick();
        req_ack = req;
        #1;
        for (int k = 0; k < NP; k++) if (port_ack[k]) glog.push_back(k);
    endtask

    initial begin
        for (int k = 0; k < NP; k++) begin
            port_id[k*IDW +: IDW] = IDW'(k + 5);
            port_addr[k*AW +: AW] = 30'h0ABC0000 + AW'(k * 'h111);
            port_len[k*RW +: RW]  = RW'(k * 3 + 1);
        end
        port_wr_n = 4'b1010;
        port_wrap = 4'b0110;

        // 1: single request, ack two cycles after req
        do_reset();
        check("t1_reset_req", {63'd0, req}, 64'd0);
        check("t1_reset_gnt", 64'(arb_gnt), 64'd0);
        port_req = 4'b0001;
        tick();
        check("t1_req_rise", {63'd0, req}, 64'd1);
        check("t1_addr", 64'(req_addr), 64'h0ABC0000);
        check("t1_id", 64'(req_id), 64'd5);
        tick();
        tick();
        req_ack = 1'b1;
        #1;
        check("t1_ack", 64'(port_ack), 64'b0001);
        tick();
        req_ack  = 1'b0;
        port_req = '0;
        check("t1_req_fall", {63'd0, req}, 64'd0);
        // stray req_ack while idle is ignored
        req_ack = 1'b1;
        #1;
        check("t1_stray_ack", 64'(port_ack), 64'd0);
        tick();
        req_ack = 1'b0;
        check("t1_stray_req", {63'd0, req}, 64'd0);

        // 2: all ports requesting in round robin
        do_reset();
        glog.delete();
        port_req = 4'b1111;
        for (int i = 0; i < 10; i++) auto_step();
        port_req = '0;
        check("t2_count", 64'(glog.size()), 64'd5);
        if (glog.size() == 5) begin
            check("t2_g0", 64'(glog[0]), 64'd0);
            check("t2_g1", 64'(glog[1]), 64'd1);
            check("t2_g2", 64'(glog[2]), 64'd2);
            check("t2_g3", 64'(glog[3]), 64'd3);
            check("t2_g4", 64'(glog[4]), 64'd0);
        end
        tick();
        req_ack = 1'b0;

        // 3: fixed priority, port 0 idle
        do_reset();
        glog.delete();
        cfg_arb_mode = 1'b1;
        port_req     = 4'b1110;
        for (int i = 0; i < 10; i++) auto_step();
        port_req = '0;
        check("t3_count", 64'(glog.size()), 64'd5);
        foreach (glog[i]) check("t3_gnt", 64'(glog[i]), 64'd1);
        tick();
        req_ack      = 1'b0;
        cfg_arb_mode = 1'b0;

        // 4: wrap-around from port 3 to port 0
        do_reset();
        glog.delete();
        port_req = 4'b1000;
        for (int i = 0; i < 20 && glog.size() < 1; i++) auto_step();
        tick();
        req_ack  = req;
        port_req = 4'b1001;
        for (int i = 0; i < 20 && glog.size() < 2; i++) auto_step();
        port_req = '0;
        check("t4_count", 64'(glog.size()), 64'd2);
        check("t4_first", 64'(glog.size() > 0 ? glog[0] : 99), 64'd3);
        check("t4_wrap", 64'(glog.size() > 1 ? glog[1] : 99), 64'd0);
        tick();
        req_ack = 1'b0;

        // 5: changes while busy are ignored; granted port drops its request
        do_reset();
        port_req = 4'b0100;
        tick();
        check("t5_gnt", 64'(arb_gnt), 64'd2);
        check("t5_busy", {63'd0, arb_busy}, 64'd1);
        port_addr[2*AW +: AW] = 30'h3FFF0000;
        cfg_arb_mode          = 1'b1;
        port_req              = 4'b0001;
        tick();
        tick();
        check("t5_addr_held", 64'(req_addr), 64'h0ABC0222);
        check("t5_req_held", {63'd0, req}, 64'd1);
        req_ack = 1'b1;
        #1;
        check("t5_ack", 64'(port_ack), 64'b0100);
        tick();
        req_ack      = 1'b0;
        port_req     = '0;
        cfg_arb_mode = 1'b0;
        check("t5_release", {63'd0, req}, 64'd0);
        tick();

        // 6: reset while busy drops the request, then port 0 wins
        do_reset();
        port_req = 4'b0010;
        tick();
        check("t6_busy", {63'd0, arb_busy}, 64'd1);
        reset    = 1'b1;
        port_req = '0;
        tick();
        check("t6_req", {63'd0, req}, 64'd0);
        check("t6_ack", 64'(port_ack), 64'd0);
        check("t6_idle", {63'd0, arb_busy}, 64'd0);
        reset    = 1'b0;
        port_req = 4'b0001;
        tick();
        check("t6_regrant", {63'd0, req}, 64'd1);
        check("t6_gnt", 64'(arb_gnt), 64'd0);
        req_ack = 1'b1;
        #1;
        check("t6_ack0", 64'(port_ack), 64'b0001);
        tick();
        req_ack  = 1'b0;
        port_req = '0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
